matrix_c_serializer: RTL and testbench
======================================

Name: matrix_c_serializer

Overview:
- Downstream stage of the matrix multiplier.
- Accepts a complete result matrix C (M x N words, flat bus) through the c_stb/c_ack handshake, snapshots it into an internal buffer, and streams the elements out one 32-bit word per beat over an out_stb/out_ack handshake.
- Frees the multiplier as soon as the matrix is captured, so the next product can be computed while the previous one drains.

Parameters:
- M, 4, rows of C.
- N, 4, columns of C.
- COL_MAJOR, 0, output order: 0 = row-major, 1 = column-major.
- WORD_WIDTH, 32, element width; localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- matrix_C  in  [0:M*N*WORD_WIDTH-1]  result matrix; element (r,c) at [(r*N+c)*WORD_WIDTH +: WORD_WIDTH], index 0 = MSB.
- c_stb  in  1  matrix_C valid (level).
- c_ack  out  1  one-cycle capture acknowledge.
- out_data  out  WORD_WIDTH  current element.
- out_row  out  $clog2(M) (min 1)  row index of out_data.
- out_col  out  $clog2(N) (min 1)  column index of out_data.
- out_last  out  1  high with the final element of the matrix.
- out_stb  out  1  out_data/out_row/out_col/out_last valid.
- out_ack  in  1  consumer accepts the element when out_stb & out_ack.
- busy  out  1  high in any state other than IDLE.
- frame_count  out  16  matrices fully streamed; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async, immediate): state = IDLE. c_ack, out_stb, out_last and busy are 0. out_data, out_row, out_col and frame_count are 0. Buffer contents are don't-care.
- States: IDLE, STREAM, RELEASE.
- IDLE:
  - out_stb = 0.
  - On c_stb = 1 at a rising edge: capture all of matrix_C into the buffer, clear the row/col counters, set c_ack = 1, go to STREAM.
- STREAM:
  - c_ack = 1 only in the first STREAM cycle, then 0.
  - out_stb = 1. out_data = buffer element (out_row, out_col).
  - Latency: c_stb seen in cycle t -> element (0,0) valid in cycle t+1.
  - Advance order, row-major: col++, wrapping to 0 with row++. Column-major: row++, wrapping to 0 with col++.
  - The counters advance only on out_stb & out_ack. Outputs stay stable while out_ack = 0.
  - out_last = 1 when the counters point at (M-1, N-1).
  - On acceptance of the last element: frame_count++. Next state is RELEASE if c_stb = 1, otherwise IDLE.
  - With out_ack held high, a full matrix takes exactly M*N cycles of out_stb.
- RELEASE:
  - out_stb = 0. Wait for c_stb = 0, then go to IDLE.
  - Guarantees that one level-high c_stb never causes a double capture.
- c_stb while in STREAM or RELEASE: ignored. matrix_C is not sampled and c_ack stays 0.
- Changes to matrix_C after capture have no effect on the stream.
- Reset mid-stream: the stream aborts at once and the partial frame is not counted.
- M = 1 or N = 1: counters are 1 bit wide and hold 0. The wrap logic still produces the correct last-element detection.

Decomposition:
- Shared package matrix_pkg:
  - WORD_WIDTH = 32.
  - Element-offset function elem_off(r, c, ncols) = (r*ncols + c)*WORD_WIDTH, shared with the multiplier and a future input loader.
  - State encoding constants.
- Sub-module: none required. The row/col counter pair with order select may be factored as matrix_index_counter for reuse by the loader.

Test Plan:
- Basic row-major. Defaults M=N=4, element (r,c) = 0x100+16r+c, c_stb pulsed one cycle, out_ack = 1.
  -> c_ack high exactly one cycle (t+1); 16 beats 0x100, 0x101 … 0x133 in cycles t+1..t+16; out_last only on 0x133; frame_count = 1; busy low again at t+17.
- Backpressure. Same stimulus, out_ack toggling 1,0,1,0.
  -> each element held stable while out_ack = 0; 16 beats in order, no duplicates or drops; out_last on the 16th accepted beat.
- Column-major, non-square. COL_MAJOR=1, M=2, N=3, elements 1..6 row-major.
  -> stream 1,4,2,5,3,6 with (row,col) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2); out_last with 6.
- Held c_stb. c_stb high throughout two frames, matrix_C changed to new values mid-stream.
  -> first frame streams the captured values only; RELEASE entered; no second capture until c_stb has been low one cycle; then the new values stream with frame_count = 2.
- Reset mid-stream. rst asserted after the 5th accepted beat.
  -> out_stb, c_ack and busy drop asynchronously in the same cycle; frame_count = 0. A fresh c_stb restarts from element (0,0).

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier family: element width,
// flat-bus element offsets and the serializer state encoding.
package matrix_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_RELEASE = 2'd2
  } ser_state_t;

  // Bit offset of element (r,c) inside a flat matrix bus whose element 0 sits at the MSB end.
  function automatic int elem_off(input int r, input int c, input int ncols);
    return (r * ncols + c) * WORD_WIDTH;
  endfunction

  // Index width for a counter over n positions; a single position still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column position counter that walks a ROWS x COLS matrix in either
// row-major or column-major order and flags the final position.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_advance,
  output logic [idx_width(ROWS)-1:0] o_row,
  output logic [idx_width(COLS)-1:0] o_col,
  output logic                       o_at_last
);

  localparam int RW = idx_width(ROWS);
  localparam int CW = idx_width(COLS);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_row_end;
  logic          w_col_end;

  // With a single row or column the end compare is always true, so that index simply holds 0.
  assign w_row_end = (r_row == RW'(ROWS - 1));
  assign w_col_end = (r_col == CW'(COLS - 1));

  // Step the fast index each advance and carry into the slow index when the fast one wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (COL_MAJOR) begin
        if (w_row_end) begin
          r_row <= '0;
          r_col <= w_col_end ? '0 : r_col + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign o_row     = r_row;
  assign o_col     = r_col;
  assign o_at_last = w_row_end & w_col_end;

endmodule

// File: rtl/matrix_c_serializer.sv
// Snapshots a finished result matrix from the multiplier and streams it out
// one word per accepted beat, so the multiplier can start the next product
// while this one drains.
module matrix_c_serializer
  import matrix_pkg::*;
#(
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int COL_MAJOR = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [0:M*N*WORD_WIDTH-1]     matrix_C,
  input  logic                          c_stb,
  output logic                          c_ack,
  output logic [WORD_WIDTH-1:0]         out_data,
  output logic [idx_width(M)-1:0]       out_row,
  output logic [idx_width(N)-1:0]       out_col,
  output logic                          out_last,
  output logic                          out_stb,
  input  logic                          out_ack,
  output logic                          busy,
  output logic [15:0]                   frame_count
);

  localparam int NE = M * N;
  localparam int IW = idx_width(NE);
  localparam int RW = idx_width(M);
  localparam int CW = idx_width(N);

  ser_state_t              r_state;
  logic                    r_c_ack;
  logic                    r_out_stb;
  logic                    r_busy;
  logic [15:0]             r_frame_count;
  logic [WORD_WIDTH-1:0]   r_mem [NE];

  logic                    w_capture;
  logic                    w_advance;
  logic                    w_at_last;
  logic [RW-1:0]           w_row;
  logic [CW-1:0]           w_col;
  logic [IW-1:0]           w_idx;

  // A new matrix is only taken from IDLE; c_stb in any other state is ignored.
  assign w_capture = (r_state == ST_IDLE) && c_stb;
  assign w_advance = r_out_stb && out_ack;

  matrix_index_counter #(
    .ROWS      (M),
    .COLS      (N),
    .COL_MAJOR (COL_MAJOR != 0)
  ) u_index (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_capture),
    .i_advance (w_advance),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_at_last (w_at_last)
  );

  // Snapshot the whole flat bus on capture so later changes upstream cannot leak into the stream.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[IW'(r * N + c)] <= matrix_C[elem_off(r, c, N) +: WORD_WIDTH];
        end
      end
    end
  end

  // Control FSM: capture in IDLE, stream until the last beat is accepted, then hold off a re-capture while c_stb stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_c_ack       <= 1'b0;
      r_out_stb     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_c_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (c_stb) begin
            r_state   <= ST_STREAM;
            r_c_ack   <= 1'b1;
            r_out_stb <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_advance && w_at_last) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_out_stb     <= 1'b0;
            if (c_stb) begin
              r_state <= ST_RELEASE;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          if (!c_stb) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_out_stb <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign w_idx       = IW'(int'(w_row) * N + int'(w_col));

  assign c_ack       = r_c_ack;
  assign out_stb     = r_out_stb;
  assign busy        = r_busy;
  assign frame_count = r_frame_count;
  assign out_row     = w_row;
  assign out_col     = w_col;
  assign out_last    = r_out_stb & w_at_last;
  assign out_data    = r_out_stb ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_matrix_c_serializer.sv
// Directed bench for matrix_c_serializer: a default 4x4 row-major instance
// and a 2x3 column-major instance, checked against hand-computed values.
module tb_matrix_c_serializer;

  localparam int M1 = 4;
  localparam int N1 = 4;
  localparam int M2 = 2;
  localparam int N2 = 3;

  typedef struct {
    logic [31:0] data;
    int          row;
    int          col;
    logic        last;
  } colVec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [0:M1*N1*32-1] matC1;
  logic                cStb1;
  logic                cAck1;
  logic [31:0]         outData1;
  logic [1:0]          outRow1;
  logic [1:0]          outCol1;
  logic                outLast1;
  logic                outStb1;
  logic                outAck1;
  logic                busy1;
  logic [15:0]         frameCount1;

  logic [0:M2*N2*32-1] matC2;
  logic                cStb2;
  logic                cAck2;
  logic [31:0]         outData2;
  logic [0:0]          outRow2;
  logic [1:0]          outCol2;
  logic                outLast2;
  logic                outStb2;
  logic                outAck2;
  logic                busy2;
  logic [15:0]         frameCount2;

  int numChecks = 0;
  int numPassed = 0;

  colVec_t colTable [6];

  // Free-running clock, period 10
  always #5 clk = ~clk;

  matrix_c_serializer #(.M(M1), .N(N1), .COL_MAJOR(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .matrix_C    (matC1),
    .c_stb       (cStb1),
    .c_ack       (cAck1),
    .out_data    (outData1),
    .out_row     (outRow1),
    .out_col     (outCol1),
    .out_last    (outLast1),
    .out_stb     (outStb1),
    .out_ack     (outAck1),
    .busy        (busy1),
    .frame_count (frameCount1)
  );

  matrix_c_serializer #(.M(M2), .N(N2), .COL_MAJOR(1)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .matrix_C    (matC2),
    .c_stb       (cStb2),
    .c_ack       (cAck2),
    .out_data    (outData2),
    .out_row     (outRow2),
    .out_col     (outCol2),
    .out_last    (outLast2),
    .out_stb     (outStb2),
    .out_ack     (outAck2),
    .busy        (busy2),
    .frame_count (frameCount2)
  );

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act === exp) numPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive the 4x4 instance's inputs, then move to 1 time unit after the next rising edge
  task automatic applyStimulus(input logic stb, input logic ack);
    cStb1   = stb;
    outAck1 = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst     = 1'b1;
    cStb1   = 1'b0;
    outAck1 = 1'b0;
    cStb2   = 1'b0;
    outAck2 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] elemA(input int r, input int c);
    return 32'h100 + 32'(16 * r + c);
  endfunction

  function automatic logic [31:0] elemB(input int r, input int c);
    return 32'h200 + 32'(16 * r + c);
  endfunction

  task automatic loadA();
    for (int r = 0; r < M1; r++)
      for (int c = 0; c < N1; c++)
        matC1[(r * N1 + c) * 32 +: 32] = elemA(r, c);
  endtask

  task automatic loadB();
    for (int r = 0; r < M1; r++)
      for (int c = 0; c < N1; c++)
        matC1[(r * N1 + c) * 32 +: 32] = elemB(r, c);
  endtask

  // Check one row-major beat of the 4x4 instance at linear position j
  task automatic checkBeat(input string tag, input int j, input logic [31:0] exp, input logic expAck);
    checkOutput({tag, "_stb"}, 32'(outStb1), 32'd1);
    checkOutput({tag, "_data"}, outData1, exp);
    checkOutput({tag, "_row"}, 32'(outRow1), 32'(j / N1));
    checkOutput({tag, "_col"}, 32'(outCol1), 32'(j % N1));
    checkOutput({tag, "_last"}, 32'(outLast1), 32'(j == M1 * N1 - 1));
    checkOutput({tag, "_cack"}, 32'(cAck1), 32'(expAck));
  endtask

  // Abort if the run ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int idx;
    int k;
    logic ack;

    colTable[0] = '{32'd1, 0, 0, 1'b0};
    colTable[1] = '{32'd4, 1, 0, 1'b0};
    colTable[2] = '{32'd2, 0, 1, 1'b0};
    colTable[3] = '{32'd5, 1, 1, 1'b0};
    colTable[4] = '{32'd3, 0, 2, 1'b0};
    colTable[5] = '{32'd6, 1, 2, 1'b1};

    matC1   = '0;
    matC2   = '0;
    cStb1   = 1'b0;
    outAck1 = 1'b0;
    cStb2   = 1'b0;
    outAck2 = 1'b0;

    // Reset state, sampled while reset is still asserted
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cack", 32'(cAck1), 32'd0);
    checkOutput("rst_stb", 32'(outStb1), 32'd0);
    checkOutput("rst_last", 32'(outLast1), 32'd0);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_data", outData1, 32'd0);
    checkOutput("rst_row", 32'(outRow1), 32'd0);
    checkOutput("rst_col", 32'(outCol1), 32'd0);
    checkOutput("rst_frames", 32'(frameCount1), 32'd0);
    rst = 1'b0;

    // Basic row-major frame with a one-cycle c_stb pulse
    doReset();
    loadA();
    applyStimulus(1'b1, 1'b1);
    cStb1 = 1'b0;
    for (int j = 0; j < M1 * N1; j++) begin
      checkBeat("basic", j, elemA(j / N1, j % N1), j == 0);
      checkOutput("basic_busy", 32'(busy1), 32'd1);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("basic_end_stb", 32'(outStb1), 32'd0);
    checkOutput("basic_end_busy", 32'(busy1), 32'd0);
    checkOutput("basic_end_frames", 32'(frameCount1), 32'd1);

    // Backpressure: out_ack alternates 1,0,1,0 starting with the first beat
    doReset();
    loadA();
    applyStimulus(1'b1, 1'b1);
    cStb1 = 1'b0;
    idx = 0;
    k = 0;
    while (idx < M1 * N1 && k < 64) begin
      ack = (k % 2 == 0);
      checkBeat("bp", idx, elemA(idx / N1, idx % N1), k == 0);
      applyStimulus(1'b0, ack);
      if (ack) idx++;
      k++;
    end
    checkOutput("bp_accepted", 32'(idx), 32'(M1 * N1));
    checkOutput("bp_cycles", 32'(k), 32'(2 * M1 * N1 - 1));
    checkOutput("bp_end_stb", 32'(outStb1), 32'd0);
    checkOutput("bp_end_frames", 32'(frameCount1), 32'd1);

    // Column-major 2x3 instance, elements 1..6 laid out row-major
    doReset();
    for (int r = 0; r < M2; r++)
      for (int c = 0; c < N2; c++)
        matC2[(r * N2 + c) * 32 +: 32] = 32'(r * N2 + c + 1);
    cStb2   = 1'b1;
    outAck2 = 1'b1;
    @(posedge clk);
    #1;
    cStb2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("cm_stb", 32'(outStb2), 32'd1);
      checkOutput("cm_data", outData2, colTable[i].data);
      checkOutput("cm_row", 32'(outRow2), 32'(colTable[i].row));
      checkOutput("cm_col", 32'(outCol2), 32'(colTable[i].col));
      checkOutput("cm_last", 32'(outLast2), 32'(colTable[i].last));
      checkOutput("cm_cack", 32'(cAck2), 32'(i == 0));
      @(posedge clk);
      #1;
    end
    checkOutput("cm_end_stb", 32'(outStb2), 32'd0);
    checkOutput("cm_end_busy", 32'(busy2), 32'd0);
    checkOutput("cm_end_frames", 32'(frameCount2), 32'd1);

    // Held c_stb across two frames, matrix changed mid-stream
    doReset();
    loadA();
    applyStimulus(1'b1, 1'b1);
    for (int j = 0; j < M1 * N1; j++) begin
      if (j == 3) loadB();
      checkBeat("held1", j, elemA(j / N1, j % N1), j == 0);
      applyStimulus(1'b1, 1'b1);
    end
    checkOutput("held_rel_stb", 32'(outStb1), 32'd0);
    checkOutput("held_rel_busy", 32'(busy1), 32'd1);
    checkOutput("held_rel_frames", 32'(frameCount1), 32'd1);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("held_wait_stb", 32'(outStb1), 32'd0);
      checkOutput("held_wait_cack", 32'(cAck1), 32'd0);
      checkOutput("held_wait_busy", 32'(busy1), 32'd1);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("held_idle_busy", 32'(busy1), 32'd0);
    checkOutput("held_idle_stb", 32'(outStb1), 32'd0);
    applyStimulus(1'b1, 1'b1);
    cStb1 = 1'b0;
    for (int j = 0; j < M1 * N1; j++) begin
      checkBeat("held2", j, elemB(j / N1, j % N1), j == 0);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("held_end_frames", 32'(frameCount1), 32'd2);
    checkOutput("held_end_busy", 32'(busy1), 32'd0);

    // Reset in the middle of a frame, then a fresh capture
    doReset();
    loadA();
    applyStimulus(1'b1, 1'b1);
    cStb1 = 1'b0;
    for (int j = 0; j < 5; j++) applyStimulus(1'b0, 1'b1);
    checkOutput("mid_pre_data", outData1, elemA(1, 1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_stb", 32'(outStb1), 32'd0);
    checkOutput("mid_rst_cack", 32'(cAck1), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy1), 32'd0);
    checkOutput("mid_rst_frames", 32'(frameCount1), 32'd0);
    checkOutput("mid_rst_row", 32'(outRow1), 32'd0);
    checkOutput("mid_rst_col", 32'(outCol1), 32'd0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    cStb1 = 1'b0;
    checkBeat("restart0", 0, elemA(0, 0), 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkBeat("restart1", 1, elemA(0, 1), 1'b0);
    checkOutput("restart_frames", 32'(frameCount1), 32'd0);

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
